// File: rtl/sqrt_rr_scheduler.sv
// Round-robin front end that shares one multi-cycle sqrt engine among NUM_REQ requesters.
// One job in flight; a watchdog aborts a hung job and pulses the engine reset.
module sqrt_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*64-1:0]   req_x,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [63:0]             rsp_y,
    output logic                    rsp_err,
    output logic                    eng_start,
    output logic [63:0]             eng_x,
    input  logic                    eng_ready,
    input  logic [63:0]             eng_y,
    output logic                    eng_reset
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned WD_W   = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_d;
    logic [NUM_REQ-1:0]  req_ready_d;
    logic                rsp_valid_d, rsp_err_d, eng_start_d, eng_reset_d;
    logic                er_hold, er_hold_d;
    logic [ID_W-1:0]     rsp_id_d, cur_id, cur_id_d;
    logic [DATA_W-1:0]   rsp_y_d, eng_x_d;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_d;
    logic [WD_W-1:0]     wd_cnt, wd_cnt_d;
    logic                rdy_q;
    logic                done_edge;
    logic                grant_ok;
    logic [IDX_W-1:0]    gnt_idx;
    logic [DATA_W-1:0]   x_arr [NUM_REQ];

    // Only a rising edge of eng_ready completes a job; a level left over from the last job does not.
    assign done_edge = eng_ready & ~rdy_q;

    always_comb begin : unpack_operands
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            x_arr[i] = req_x[i*DATA_W +: DATA_W];
        end
    end

    // First valid requester after the last grant, wrapping around.
    always_comb begin : rr_search
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        grant_ok = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_ok && req_valid[cand_idx]) begin
                grant_ok = 1'b1;
                gnt_idx  = cand_idx;
            end
        end
    end

    always_comb begin : fsm_next
        state_d     = state;
        req_ready_d = '0;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_y_d     = rsp_y;
        rsp_err_d   = rsp_err;
        eng_start_d = 1'b0;
        eng_x_d     = eng_x;
        eng_reset_d = er_hold;
        er_hold_d   = 1'b0;
        rr_ptr_d    = rr_ptr;
        cur_id_d    = cur_id;
        wd_cnt_d    = wd_cnt;
        unique case (state)
            IDLE: begin
                // Hold off new work while the engine is still being reset.
                if (grant_ok && !eng_reset) begin
                    req_ready_d[gnt_idx] = 1'b1;
                    eng_x_d              = x_arr[gnt_idx];
                    cur_id_d             = ID_W'(gnt_idx);
                    rr_ptr_d             = gnt_idx;
                    state_d              = ISSUE;
                end
            end
            ISSUE: begin
                eng_start_d = 1'b1;
                wd_cnt_d    = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (done_edge) begin
                    rsp_y_d     = eng_y;
                    rsp_id_d    = cur_id;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    rsp_y_d     = '0;
                    rsp_id_d    = cur_id;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    eng_reset_d = 1'b1;
                    er_hold_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    wd_cnt_d = wd_cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_err   <= 1'b0;
            eng_start <= 1'b0;
            eng_x     <= '0;
            eng_reset <= 1'b1;
            er_hold   <= 1'b0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            cur_id    <= '0;
            wd_cnt    <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state     <= state_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_y     <= rsp_y_d;
            rsp_err   <= rsp_err_d;
            eng_start <= eng_start_d;
            eng_x     <= eng_x_d;
            eng_reset <= eng_reset_d;
            er_hold   <= er_hold_d;
            rr_ptr    <= rr_ptr_d;
            cur_id    <= cur_id_d;
            wd_cnt    <= wd_cnt_d;
            rdy_q     <= eng_ready;
        end
    end

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Bench for sqrt_rr_scheduler: behavioural engine, requester model, scoreboard of tagged results.
module tb_sqrt_rr_scheduler;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [63:0] MAGIC   = 64'h5FE6EC85E7DE30DA;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*64-1:0] req_x = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [ID_W-1:0]       rsp_id;
    logic [63:0]           rsp_y;
    logic                  rsp_err;
    logic                  eng_start;
    logic [63:0]           eng_x;
    logic                  eng_ready = 1'b0;
    logic [63:0]           eng_y = '0;
    logic                  eng_reset;

    always #5 clock = ~clock;

    sqrt_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_x(eng_x), .eng_ready(eng_ready),
        .eng_y(eng_y), .eng_reset(eng_reset)
    );

    // Engine: captures x the edge after start, raises ready four edges later; ready stays high until next start.
    logic        eng_hang = 1'b0;
    logic        eng_stick = 1'b0;
    logic        e_busy = 1'b0;
    int          e_cnt = 0;
    logic [63:0] e_x = '0;
    always @(posedge clock) begin
        if (eng_reset === 1'b1) begin
            e_busy <= 1'b0; e_cnt <= 0; eng_ready <= 1'b0;
        end else if (eng_start === 1'b1) begin
            e_busy <= 1'b1; e_cnt <= 1; e_x <= eng_x;
            if (!eng_stick) eng_ready <= 1'b0;
        end else if (e_busy) begin
            e_cnt <= e_cnt + 1;
            if (e_cnt == 3 && eng_stick) eng_ready <= 1'b0;
            if (e_cnt == 4) begin
                e_busy <= 1'b0;
                if (!eng_hang) begin
                    eng_ready <= 1'b1;
                    eng_y     <= MAGIC - (e_x >> 1);
                end
            end
        end
    end

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     y;
        logic            err;
    } exp_t;

    typedef struct {
        int          id;
        logic [63:0] x;
        logic        hang;
        logic        stick;
        logic [63:0] y;
        logic        err;
        int          lat;
    } vec_t;

    exp_t        sb[$];
    int          grant_log[$];
    logic [63:0] exp_y_of [NUM_REQ];
    logic        exp_err_of [NUM_REQ];
    int          n_pass = 0, n_total = 0;
    int          cyc = 0;
    bit          acc_flag, rsp_flag;
    int          acc_id, acc_cyc, rsp_cyc, rsp_count;
    logic        prev_er = 1'b1;
    int          er_run = 0, er_len = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
        check({tag, "_rsp_y"},     rsp_y,          64'd0);
        check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
        check({tag, "_eng_start"}, 64'(eng_start), 64'd0);
        check({tag, "_eng_x"},     eng_x,          64'd0);
        check({tag, "_eng_reset"}, 64'(eng_reset), 64'd1);
    endtask

    task automatic post(input int i, input logic [63:0] x, input logic [63:0] ey, input logic eerr);
        req_x[i*64 +: 64] = x;
        req_valid[i]      = 1'b1;
        exp_y_of[i]       = ey;
        exp_err_of[i]     = eerr;
    endtask

    // One clock: sample at negedge (accepts, responses), then retire accepted requests after the edge.
    task automatic tick();
        logic [NUM_REQ-1:0] acc;
        exp_t               e;
        @(negedge clock);
        acc = req_valid & req_ready;
        if (req_ready != '0) begin
            check("req_ready_onehot", 64'($onehot(req_ready) && (acc == req_ready)), 64'd1);
            check("grant_after_eng_reset", 64'(prev_er), 64'd0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    e.id = ID_W'(i); e.y = exp_y_of[i]; e.err = exp_err_of[i];
                    sb.push_back(e);
                    grant_log.push_back(i);
                    acc_flag = 1'b1; acc_id = i; acc_cyc = cyc;
                end
            end
        end
        if (rsp_valid === 1'b1 && rsp_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: actual=response id %0d required=none", rsp_id);
            end else begin
                e = sb.pop_front();
                check("rsp_id",  64'(rsp_id),  64'(e.id));
                check("rsp_y",   rsp_y,        e.y);
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
            rsp_flag = 1'b1; rsp_cyc = cyc; rsp_count++;
        end
        if (eng_reset === 1'b1) er_run++;
        else begin
            if (er_run > 0) er_len = er_run;
            er_run = 0;
        end
        prev_er = eng_reset;
        @(posedge clock); #1;
        req_valid = req_valid & ~acc;
        cyc++;
    endtask

    task automatic wait_acc(input int budget, output bit ok);
        acc_flag = 1'b0;
        for (int n = 0; n < budget && !acc_flag; n++) tick();
        ok = acc_flag;
        check("accept_within_budget", 64'(ok), 64'd1);
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        rsp_flag = 1'b0;
        for (int n = 0; n < budget && !rsp_flag; n++) tick();
        ok = rsp_flag;
        check("rsp_within_budget", 64'(ok), 64'd1);
    endtask

    vec_t        vecs [6];
    int          order [5];
    bit          ok, repost_done, stable;
    int          a_cyc;
    logic [ID_W-1:0] hold_id;
    logic [63:0] hold_y;
    logic        hold_err;

    initial begin
        vecs[0] = '{0, 64'h4,                0, 0, 64'h5FE6EC85E7DE30D8, 0, 7};
        vecs[1] = '{2, 64'h100,              0, 0, 64'h5FE6EC85E7DE305A, 0, 7};
        vecs[2] = '{3, 64'hFFFFFFFFFFFFFFFF, 0, 0, 64'hDFE6EC85E7DE30DB, 0, 7};
        vecs[3] = '{1, 64'h0,                0, 1, 64'h5FE6EC85E7DE30DA, 0, 7};
        vecs[4] = '{2, 64'h1234,             1, 0, 64'h0,                1, TIMEOUT + 1};
        vecs[5] = '{0, 64'h10,               0, 0, 64'h5FE6EC85E7DE30D2, 0, 7};
        order   = '{0, 1, 2, 3, 0};

        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 check_reset_vals("init");
        reset = 1'b1;

        // All four requesting from reset; requester 0 re-requests after its first grant.
        grant_log.delete();
        rsp_count = 0;
        for (int i = 0; i < NUM_REQ; i++) post(i, 64'(i) << 4, MAGIC - 64'(8 * i), 1'b0);
        tick();
        check("eng_reset_release", 64'(eng_reset), 64'd0);
        repost_done = 1'b0;
        for (int n = 0; n < 300 && rsp_count < 5; n++) begin
            tick();
            if (!repost_done && grant_log.size() >= 1) begin
                post(0, 64'h40, MAGIC - 64'h20, 1'b0);
                repost_done = 1'b1;
            end
        end
        check("t2_rsp_count", 64'(rsp_count), 64'd5);
        for (int k = 0; k < 5; k++)
            check("t2_grant_order", 64'((k < grant_log.size()) ? grant_log[k] : -1), 64'(order[k]));

        // Single-job vectors: grant id, accept-to-response latency, tagged result.
        foreach (vecs[v]) begin
            eng_hang  = vecs[v].hang;
            eng_stick = vecs[v].stick;
            if (vecs[v].hang) er_len = 0;
            post(vecs[v].id, vecs[v].x, vecs[v].y, vecs[v].err);
            wait_acc(50, ok);
            if (ok) check("vec_grant_id", 64'(acc_id), 64'(vecs[v].id));
            a_cyc = acc_cyc;
            wait_rsp(40, ok);
            if (ok) check("vec_latency", 64'(rsp_cyc - a_cyc), 64'(vecs[v].lat));
            if (v > 0 && vecs[v-1].hang) check("abort_eng_reset_cycles", 64'(er_len), 64'd2);
        end
        eng_hang  = 1'b0;
        eng_stick = 1'b0;

        // Consumer stall: response held stable, no new grant until released.
        rsp_ready = 1'b0;
        post(1, 64'h20, MAGIC - 64'h10, 1'b0);
        wait_acc(50, ok);
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            tick();
            ok = (rsp_valid === 1'b1);
        end
        check("t3_rsp_valid_seen", 64'(ok), 64'd1);
        post(2, 64'h60, MAGIC - 64'h30, 1'b0);
        hold_id = rsp_id; hold_y = rsp_y; hold_err = rsp_err;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_id !== hold_id || rsp_y !== hold_y ||
                rsp_err !== hold_err || req_ready !== '0) stable = 1'b0;
        end
        check("t3_stall_stable", 64'(stable), 64'd1);
        check("t3_held_y", hold_y, MAGIC - 64'h10);
        rsp_ready = 1'b1;
        tick();
        check("t3_rsp_valid_drop", 64'(rsp_valid), 64'd0);
        wait_acc(10, ok);
        if (ok) check("t3_next_grant", 64'(acc_id), 64'd2);
        wait_rsp(40, ok);

        // Reset in the middle of a job: immediate reset values, job dropped, pointer restarts.
        post(1, 64'h30, MAGIC - 64'h18, 1'b0);
        wait_acc(50, ok);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1 check_reset_vals("midjob");
        sb.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        post(1, 64'h50, MAGIC - 64'h28, 1'b0);
        post(3, 64'h70, MAGIC - 64'h38, 1'b0);
        wait_acc(20, ok);
        if (ok) check("t5_grant_lowest", 64'(acc_id), 64'd1);
        wait_rsp(40, ok);
        wait_acc(20, ok);
        if (ok) check("t5_grant_next", 64'(acc_id), 64'd3);
        wait_rsp(40, ok);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
